i2c_peripheral: RTL and testbench



---
 rtl/i2c_peripheral.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_i2c_peripheral.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_peripheral.sv
// I2C target with a 7-bit address, open-drain SDA and oversampled SCL/SDA.
// Define CLOCK_STRETCH_EN to hold SCL low while waiting on tx_valid/rx_ready.
module i2c_peripheral #(
  parameter logic [6:0] ADDRESS         = 7'h5A,
  parameter bit         WRITE_BIT_LEVEL = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        sda,
  inout  wire        scl,
  output logic       busy,
  output logic       read_mode,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_req
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WRITE_DATA,
    S_WRITE_ACK,
    S_READ_DATA,
    S_READ_ACK,
    S_IGNORE
  } state_t;

  state_t     r_state, w_state_nx;
  logic [2:0] r_cnt, w_cnt_nx;
  logic [7:0] r_shift, w_shift_nx;
  logic       r_ph, w_ph_nx;
  logic       r_pend, w_pend_nx;
  logic       r_sda_low, w_sda_low_nx;
  logic       r_scl_low, w_scl_low_nx;
  logic [7:0] r_tx_byte, w_tx_byte_nx;
  logic       r_busy, w_busy_nx;
  logic       r_read_mode, w_read_mode_nx;
  logic [7:0] r_rx_data, w_rx_data_nx;
  logic       r_rx_valid, w_rx_valid_nx;
  logic       r_tx_req, w_tx_req_nx;
  logic       w_load;

  logic r_scl_s1, r_scl_s2, r_scl_h;
  logic r_sda_s1, r_sda_s2, r_sda_h;

  logic       w_rise, w_fall, w_start, w_stop;
  logic [7:0] w_byte;
  logic [2:0] w_cnt_m1;
  logic       w_tx_ok;

  assign w_rise   = r_scl_s2 & ~r_scl_h;
  assign w_fall   = ~r_scl_s2 & r_scl_h;
  assign w_start  = r_scl_s2 & r_scl_h & r_sda_h & ~r_sda_s2;
  assign w_stop   = r_scl_s2 & r_scl_h & ~r_sda_h & r_sda_s2;
  assign w_byte   = {r_shift[6:0], r_sda_s2};
  assign w_cnt_m1 = r_cnt - 3'd1;

`ifdef CLOCK_STRETCH_EN
  assign w_tx_ok = tx_valid;
`else
  wire w_unused_tx_valid = tx_valid;
  assign w_tx_ok = 1'b1;
`endif

  always_comb begin
    w_state_nx     = r_state;
    w_cnt_nx       = r_cnt;
    w_shift_nx     = r_shift;
    w_ph_nx        = r_ph;
    w_pend_nx      = r_pend;
    w_sda_low_nx   = r_sda_low;
    w_scl_low_nx   = r_scl_low;
    w_tx_byte_nx   = r_tx_byte;
    w_busy_nx      = r_busy;
    w_read_mode_nx = r_read_mode;
    w_rx_data_nx   = r_rx_data;
    w_rx_valid_nx  = 1'b0;
    w_tx_req_nx    = 1'b0;
    w_load         = 1'b0;
    if (w_stop) begin
      w_state_nx     = S_IDLE;
      w_busy_nx      = 1'b0;
      w_read_mode_nx = 1'b0;
      w_sda_low_nx   = 1'b0;
      w_scl_low_nx   = 1'b0;
      w_pend_nx      = 1'b0;
    end else if (w_start) begin
      w_state_nx     = S_ADDR;
      w_cnt_nx       = 3'd7;
      w_ph_nx        = 1'b0;
      w_busy_nx      = 1'b0;
      w_read_mode_nx = 1'b0;
      w_sda_low_nx   = 1'b0;
      w_scl_low_nx   = 1'b0;
      w_pend_nx      = 1'b0;
    end else if (r_scl_low) begin
      // Stretching: resume once the fabric side is ready.
      if (r_state == S_WRITE_ACK) begin
        if (rx_ready) begin
          w_rx_data_nx  = r_shift;
          w_rx_valid_nx = 1'b1;
          w_sda_low_nx  = 1'b1;
          w_scl_low_nx  = 1'b0;
          w_pend_nx     = 1'b0;
          w_ph_nx       = 1'b1;
        end
      end else begin
        w_load = 1'b1;
      end
    end else begin
      unique case (r_state)
        S_ADDR: begin
          if (w_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = w_cnt_m1;
            if (r_cnt == 3'd0) begin
              if (w_byte[7:1] == ADDRESS) begin
                w_state_nx     = S_ADDR_ACK;
                w_ph_nx        = 1'b0;
                w_busy_nx      = 1'b1;
                w_read_mode_nx = (w_byte[0] != WRITE_BIT_LEVEL);
              end else begin
                w_state_nx = S_IGNORE;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (!r_ph) begin
            if (w_fall) begin
              w_sda_low_nx = 1'b1;
              w_ph_nx      = 1'b1;
            end
          end else if (w_rise) begin
            w_tx_req_nx = r_read_mode;
          end else if (w_fall) begin
            if (r_read_mode) begin
              w_load = 1'b1;
            end else begin
              w_sda_low_nx = 1'b0;
              w_cnt_nx     = 3'd7;
              w_state_nx   = S_WRITE_DATA;
            end
          end
        end
        S_WRITE_DATA: begin
          if (w_rise) begin
            w_shift_nx = w_byte;
            w_cnt_nx   = w_cnt_m1;
            if (r_cnt == 3'd0) begin
              w_ph_nx = 1'b0;
              if (rx_ready) begin
                w_rx_data_nx  = w_byte;
                w_rx_valid_nx = 1'b1;
                w_state_nx    = S_WRITE_ACK;
              end else begin
`ifdef CLOCK_STRETCH_EN
                w_pend_nx  = 1'b1;
                w_state_nx = S_WRITE_ACK;
`else
                w_state_nx = S_IGNORE;
`endif
              end
            end
          end
        end
        S_WRITE_ACK: begin
          if (w_fall) begin
            if (r_ph) begin
              w_sda_low_nx = 1'b0;
              w_cnt_nx     = 3'd7;
              w_state_nx   = S_WRITE_DATA;
            end else if (r_pend) begin
              w_scl_low_nx = 1'b1;
            end else begin
              w_sda_low_nx = 1'b1;
              w_ph_nx      = 1'b1;
            end
          end
        end
        S_READ_DATA: begin
          if (w_fall) begin
            if (r_cnt == 3'd0) begin
              w_sda_low_nx = 1'b0;
              w_ph_nx      = 1'b0;
              w_state_nx   = S_READ_ACK;
            end else begin
              w_cnt_nx     = w_cnt_m1;
              w_sda_low_nx = ~r_tx_byte[w_cnt_m1];
            end
          end
        end
        S_READ_ACK: begin
          if (!r_ph) begin
            if (w_rise) begin
              if (!r_sda_s2) begin
                w_tx_req_nx = 1'b1;
                w_ph_nx     = 1'b1;
              end else begin
                w_state_nx = S_IGNORE;
              end
            end
          end else if (w_fall) begin
            w_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
    // Next read byte: present bit 7 now, or hold SCL until it arrives.
    if (w_load) begin
      if (w_tx_ok) begin
        w_tx_byte_nx = tx_data;
        w_sda_low_nx = ~tx_data[7];
        w_cnt_nx     = 3'd7;
        w_scl_low_nx = 1'b0;
        w_state_nx   = S_READ_DATA;
      end else begin
        w_sda_low_nx = 1'b0;
        w_scl_low_nx = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scl_s1    <= 1'b1;
      r_scl_s2    <= 1'b1;
      r_scl_h     <= 1'b1;
      r_sda_s1    <= 1'b1;
      r_sda_s2    <= 1'b1;
      r_sda_h     <= 1'b1;
      r_state     <= S_IDLE;
      r_cnt       <= 3'd7;
      r_shift     <= 8'h00;
      r_ph        <= 1'b0;
      r_pend      <= 1'b0;
      r_sda_low   <= 1'b0;
      r_scl_low   <= 1'b0;
      r_tx_byte   <= 8'h00;
      r_busy      <= 1'b0;
      r_read_mode <= 1'b0;
      r_rx_data   <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_tx_req    <= 1'b0;
    end else begin
      r_scl_s1    <= scl;
      r_scl_s2    <= r_scl_s1;
      r_scl_h     <= r_scl_s2;
      r_sda_s1    <= sda;
      r_sda_s2    <= r_sda_s1;
      r_sda_h     <= r_sda_s2;
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_shift     <= w_shift_nx;
      r_ph        <= w_ph_nx;
      r_pend      <= w_pend_nx;
      r_sda_low   <= w_sda_low_nx;
      r_scl_low   <= w_scl_low_nx;
      r_tx_byte   <= w_tx_byte_nx;
      r_busy      <= w_busy_nx;
      r_read_mode <= w_read_mode_nx;
      r_rx_data   <= w_rx_data_nx;
      r_rx_valid  <= w_rx_valid_nx;
      r_tx_req    <= w_tx_req_nx;
    end
  end

  assign sda       = r_sda_low ? 1'b0 : 1'bz;
  assign scl       = r_scl_low ? 1'b0 : 1'bz;
  assign busy      = r_busy;
  assign read_mode = r_read_mode;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign tx_req    = r_tx_req;

endmodule

// File: tb/tb_i2c_peripheral.sv
// Bench for i2c_peripheral: bit-banged controller plus a transaction-level
// model of what the target should ACK, deliver and request.
`timescale 1ns/1ps
module tb_i2c_peripheral;

  localparam int Q = 10;

  logic clk = 1'b0;
  logic reset;
  wire  sda, scl;
  pullup (sda);
  pullup (scl);

  logic m_sda_low = 1'b0;
  logic m_scl_low = 1'b0;
  assign sda = m_sda_low ? 1'b0 : 1'bz;
  assign scl = m_scl_low ? 1'b0 : 1'bz;

  logic       busy, read_mode, rx_valid, rx_ready, tx_valid, tx_req;
  logic [7:0] rx_data, tx_data;

  int n_tests = 0;
  int n_fail  = 0;
  int rx_cnt, req_cnt;
  logic [7:0] rx_q[$];
  logic [7:0] tx_q[$];
  bit dut_pull;
  bit stretch_en;

  always #5 clk = ~clk;

  i2c_peripheral dut (
    .clk       (clk),
    .reset     (reset),
    .sda       (sda),
    .scl       (scl),
    .busy      (busy),
    .read_mode (read_mode),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_req    (tx_req)
  );

  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        rx_cnt++;
        rx_q.push_back(rx_data);
      end
      if (tx_req) begin
        req_cnt++;
        if (tx_q.size() > 0) tx_data = tx_q.pop_front();
      end
      if (sda == 1'b0 && !m_sda_low) dut_pull = 1'b1;
    end
  end

`ifdef CLOCK_STRETCH_EN
  always @(negedge clk) begin
    if (!reset && scl == 1'b0 && !m_scl_low && !rx_ready) begin
      repeat (20) @(negedge clk);
      rx_ready = 1'b1;
    end
  end
`endif

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic scl_up();
    int k = 0;
    m_scl_low = 1'b0;
    while (scl != 1'b1 && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("scl_high", 32'(scl), 32'd1);
  endtask

  task automatic clk_bit(input bit b, output bit s);
    m_sda_low = !b;
    wait_q();
    scl_up();
    wait_q();
    s = sda;
    wait_q();
    m_scl_low = 1'b1;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0;
    wait_q();
    scl_up();
    wait_q();
    m_sda_low = 1'b1;
    wait_q();
    m_scl_low = 1'b1;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1;
    wait_q();
    scl_up();
    wait_q();
    m_sda_low = 1'b0;
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    bit s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input bit ack, output logic [7:0] d);
    bit s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, s);
      d[i] = s;
    end
    clk_bit(ack, s);
  endtask

  task automatic clear_mon();
    rx_cnt = 0;
    req_cnt = 0;
    rx_q.delete();
    tx_q.delete();
    dut_pull = 1'b0;
  endtask

  // One transaction, with expectations drawn from the protocol rules.
  task automatic run_txn(input logic [6:0] a, input bit rd, input int n,
                         input bit rdy);
    logic [7:0] bytes[$];
    logic [7:0] d;
    bit ack;
    bit match;
    bit wr_ok;
    int exp_rx;
    int exp_req;
    match = (a == 7'h5A);
    wr_ok = match && (rdy || stretch_en);
    clear_mon();
    rx_ready = rdy;
    tx_valid = 1'b1;
    tx_data  = 8'($urandom_range(0, 255));
    for (int i = 0; i < n; i++) bytes.push_back(8'($urandom_range(0, 255)));
    if (rd && match) foreach (bytes[i]) tx_q.push_back(bytes[i]);
    exp_rx  = (!rd && wr_ok) ? n : 0;
    exp_req = (rd && match) ? n : 0;
    i2c_start();
    send_byte({a, rd}, ack);
    check("addr_ack", 32'(ack), 32'(!match));
    check("busy_match", 32'(busy), 32'(match));
    if (match) check("read_mode", 32'(read_mode), 32'(rd));
    if (!rd) begin
      for (int i = 0; i < n; i++) begin
        send_byte(bytes[i], ack);
        check("wr_ack", 32'(ack), 32'(!wr_ok));
      end
    end else if (match) begin
      for (int i = 0; i < n; i++) begin
        recv_byte(i == n - 1, d);
        check("rd_data", 32'(d), 32'(bytes[i]));
      end
    end else begin
      recv_byte(1'b1, d);
      check("rd_ignored", 32'(d), 32'hFF);
    end
    i2c_stop();
    wait_q();
    check("busy_stop", 32'(busy), 32'd0);
    check("rx_count", 32'(rx_cnt), 32'(exp_rx));
    check("req_count", 32'(req_cnt), 32'(exp_req));
    if (exp_rx == n && !rd) begin
      for (int i = 0; i < n && i < rx_q.size(); i++)
        check("rx_byte", 32'(rx_q[i]), 32'(bytes[i]));
    end
    if (!match) check("no_pull", 32'(dut_pull), 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    bit ack;
    logic [6:0] a;
    stretch_en = 1'b0;
`ifdef CLOCK_STRETCH_EN
    stretch_en = 1'b1;
`endif
    reset    = 1'b1;
    rx_ready = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h00;
    clear_mon();
    repeat (3) @(negedge clk);
    check("rst_sda", 32'(sda), 32'd1);
    check("rst_scl", 32'(scl), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rmode", 32'(read_mode), 32'd0);
    check("rst_rxdata", 32'(rx_data), 32'd0);
    check("rst_rxvalid", 32'(rx_valid), 32'd0);
    check("rst_txreq", 32'(tx_req), 32'd0);
    reset = 1'b0;
    wait_q();

    run_txn(7'h5A, 1'b0, 1, 1'b1);
    run_txn(7'h5B, 1'b0, 1, 1'b1);
    run_txn(7'h5A, 1'b1, 2, 1'b1);
    run_txn(7'h5A, 1'b0, 2, 1'b0);

    // Write 0x11, then repeated START into a read returning 0x77.
    clear_mon();
    rx_ready = 1'b1;
    i2c_start();
    send_byte(8'hB4, ack);
    check("rs_addr_ack", 32'(ack), 32'd0);
    send_byte(8'h11, ack);
    check("rs_wr_ack", 32'(ack), 32'd0);
    tx_q.push_back(8'h77);
    i2c_start();
    check("rs_busy_clr", 32'(busy), 32'd0);
    send_byte(8'hB5, ack);
    check("rs_rd_ack", 32'(ack), 32'd0);
    check("rs_rmode", 32'(read_mode), 32'd1);
    recv_byte(1'b1, d);
    check("rs_rd_data", 32'(d), 32'h77);
    i2c_stop();
    wait_q();
    check("rs_rxdata", 32'(rx_data), 32'h11);
    check("rs_rxcnt", 32'(rx_cnt), 32'd1);
    check("rs_reqcnt", 32'(req_cnt), 32'd1);

    // Reset while the target is driving a 0 data bit.
    clear_mon();
    tx_q.push_back(8'h00);
    i2c_start();
    send_byte(8'hB5, ack);
    check("mr_addr_ack", 32'(ack), 32'd0);
    check("mr_drive0", 32'(sda), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mr_sda_rel", 32'(sda), 32'd1);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_rmode", 32'(read_mode), 32'd0);
    check("mr_rxdata", 32'(rx_data), 32'd0);
    check("mr_txreq", 32'(tx_req), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    i2c_stop();
    run_txn(7'h5A, 1'b0, 2, 1'b1);

    for (int t = 0; t < 12; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        a = 7'($urandom_range(0, 127));
        if (a == 7'h5A) a = 7'h5B;
      end else begin
        a = 7'h5A;
      end
      run_txn(a, 1'($urandom_range(0, 1)), $urandom_range(1, 3),
              $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
